crc_checker: RTL and testbench
==============================

// Module: crc_checker
// PURPOSE
//  Receive-side CAN CRC-15 checker: the counterpart of the transmit CRC generator.
//  Consumes the destuffed receive bitstream serially, MSB first, from SOF through the last data bit.
//  Runs the CRC-15 LFSR over those bits, captures the 15 received CRC-field bits and compares the two.
//  Reports a done pulse with crc_ok/crc_err to the receive frame FSM, ahead of the CRC delimiter.
// PARAMETERS
//  LEN_W    7         width of data_bits; covers the longest extended frame (<=103 bits)
//  CRC_POLY 15'h4599  x^15+x^14+x^10+x^8+x^7+x^4+x^3+1, x^15 term implicit
// PORTS
//  clk          in   1      clock; single clock domain
//  rst_n        in   1      asynchronous active-low reset
//  frame_start  in   1      1-cycle pulse; SOF seen, latch data_bits, begin new frame
//  data_bits    in   LEN_W  number of bits covered by the CRC (SOF..last data bit), sampled on frame_start
//  bit_valid    in   1      qualifies bit_in; one destuffed bit per asserted cycle, arbitrary gaps
//  bit_in       in   1      destuffed received bit
//  abort        in   1      bus/form error; drop current frame
//  busy         out  1      high in DATA or CRC state
//  done         out  1      1-cycle pulse; result valid
//  crc_ok       out  1      received CRC == calculated CRC; held until next frame_start
//  crc_err      out  1      mismatch; held until next frame_start
//  crc_calc     out  15     calculated CRC; held with result
// BEHAVIOUR
//  Reset (async): state=IDLE, LFSR=0, rx_crc=0, count=0; busy=done=crc_ok=crc_err=0; crc_calc=0.
//  FSM states: IDLE -> DATA -> CRC -> DONE -> IDLE.
//  - IDLE: on frame_start, latch len=data_bits, clear LFSR/rx_crc/count/crc_ok/crc_err.
//    Go to DATA, or to CRC if len==0.
//  - DATA: per bit_valid, nxt=bit_in^lfsr[14]; lfsr={lfsr[13:0],1'b0}^(nxt?CRC_POLY:0); count++.
//    Leave for CRC on the valid cycle where count==len-1; count cleared.
//  - CRC: per bit_valid, rx_crc={rx_crc[13:0],bit_in}; count++.
//    On the 15th valid bit, go to DONE.
//  - DONE (1 cycle): done=1; crc_ok=(rx_crc==lfsr), crc_err=~crc_ok; crc_calc=lfsr. Then IDLE.
//  - Latency: done/crc_ok/crc_err are registered and assert on the cycle after the 15th CRC bit is accepted.
//  - Clock-enable: bit_valid low = no change to LFSR, count or rx_crc; gaps of any length are legal.
//  - bit_valid outside DATA/CRC is ignored.
//  - abort in DATA/CRC/DONE: go to IDLE next cycle, no done, crc_ok=crc_err=0. abort beats frame_start.
//  - frame_start in DATA/CRC: restart; the partial frame is discarded, no done.
//  - frame_start in DONE: done still pulses for the old frame; the new frame is latched the same cycle.
//    The next state is DATA, and crc_ok/crc_err reflect the old frame only during the done cycle.
//  - frame_start with bit_valid in the same cycle: that bit is NOT consumed; first data bit comes later.
//  - crc_ok and crc_err are never both 1; both 0 until the first result.
//  - Reset mid-frame: immediate return to reset values, no done.
// STRUCTURE
//  Shared CAN package: CRC15_POLY, CRC15_W=15, state encoding constants.
//  The TX generator uses the same package constants.
//  One sub-module, crc15_lfsr_step: combinational next-LFSR (bit, lfsr -> lfsr'), also reusable by TX.
//  Counter width is LEN_W; the CRC phase reuses the counter (needs >=4 bits).
// TESTING
//  1. len=1, bits "1", CRC field 0x4599 -> done after 16 valid bits + 1 cycle; crc_ok=1, crc_calc=0x4599.
//  2. len=1, bits "1", CRC field 0x4598 -> crc_err=1, crc_ok=0, crc_calc=0x4599.
//  3. len=2, bits "10", CRC 0x4EAB, random 0-5 cycle bit_valid gaps -> crc_ok=1, same as gapless.
//  4. len=8, all-zero data, CRC 0x0000 -> crc_ok=1; len=0, CRC 0x0000 -> crc_ok=1 after 15 bits.
//  5. abort after 5 CRC bits, or frame_start mid-DATA -> no done, busy drops/restarts, next frame checks clean.
//  6. rst_n low mid-CRC, async (between clock edges) -> all outputs 0 immediately; next frame of case 1 gives crc_ok.

Source files
------------

// File: rtl/crc_checker_pkg.sv
// Shared CAN CRC-15 constants and receive-checker state encoding.
// The transmit-side CRC generator uses the same polynomial and width.
package crc_checker_pkg;

  localparam int unsigned     CRC15_W    = 15;
  localparam logic [14:0]     CRC15_POLY = 15'h4599;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_CRC  = 2'd2,
    ST_DONE = 2'd3
  } crc_state_e;

endpackage

// File: rtl/crc_checker_lfsr.sv
// One serial step of the CAN CRC-15 LFSR, MSB first; combinational.
// Shared with the transmit CRC generator.
module crc15_lfsr_step
  import crc_checker_pkg::*;
#(
  parameter logic [14:0] POLY = CRC15_POLY
) (
  input  logic        bit_in,
  input  logic [14:0] lfsr_in,
  output logic [14:0] lfsr_out
);

  logic nxt;

  always_comb begin
    nxt      = bit_in ^ lfsr_in[14];
    lfsr_out = {lfsr_in[13:0], 1'b0} ^ (nxt ? POLY : '0);
  end

endmodule

// File: rtl/crc_checker.sv
// Receive-side CAN CRC-15 checker: runs the LFSR over SOF..last data bit,
// captures the 15 received CRC bits and reports a match/mismatch pulse.
module crc_checker
  import crc_checker_pkg::*;
#(
  parameter int unsigned LEN_W    = 7,
  parameter logic [14:0] CRC_POLY = CRC15_POLY
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic [LEN_W-1:0] data_bits,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic [14:0]      crc_calc
);

  crc_state_e        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [14:0]       lfsr_q, lfsr_d;
  logic [14:0]       rx_crc_q, rx_crc_d;
  logic [14:0]       crc_calc_q, crc_calc_d;
  logic              done_q, done_d;
  logic              crc_ok_q, crc_ok_d;
  logic              crc_err_q, crc_err_d;
  logic [14:0]       lfsr_step;

  crc15_lfsr_step #(
    .POLY (CRC_POLY)
  ) u_step (
    .bit_in   (bit_in),
    .lfsr_in  (lfsr_q),
    .lfsr_out (lfsr_step)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    count_d    = count_q;
    lfsr_d     = lfsr_q;
    rx_crc_d   = rx_crc_q;
    crc_calc_d = crc_calc_q;
    done_d     = 1'b0;
    crc_ok_d   = crc_ok_q;
    crc_err_d  = crc_err_q;

    // Priority: abort, then frame_start (restart), then bit consumption.
    if (abort) begin
      if (state_q != ST_IDLE) begin
        state_d   = ST_IDLE;
        crc_ok_d  = 1'b0;
        crc_err_d = 1'b0;
      end
    end else if (frame_start) begin
      len_d     = data_bits;
      lfsr_d    = '0;
      rx_crc_d  = '0;
      count_d   = '0;
      crc_ok_d  = 1'b0;
      crc_err_d = 1'b0;
      state_d   = (data_bits == '0) ? ST_CRC : ST_DATA;
    end else begin
      case (state_q)
        ST_DATA: begin
          if (bit_valid) begin
            lfsr_d  = lfsr_step;
            count_d = count_q + 1'b1;
            if (count_q == len_q - 1'b1) begin
              count_d = '0;
              state_d = ST_CRC;
            end
          end
        end
        ST_CRC: begin
          if (bit_valid) begin
            rx_crc_d = {rx_crc_q[13:0], bit_in};
            count_d  = count_q + 1'b1;
            // Result is registered here so it is visible during the DONE cycle.
            if (count_q == LEN_W'(CRC15_W - 1)) begin
              count_d    = '0;
              state_d    = ST_DONE;
              done_d     = 1'b1;
              crc_ok_d   = (rx_crc_d == lfsr_q);
              crc_err_d  = (rx_crc_d != lfsr_q);
              crc_calc_d = lfsr_q;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      count_q    <= '0;
      lfsr_q     <= '0;
      rx_crc_q   <= '0;
      crc_calc_q <= '0;
      done_q     <= 1'b0;
      crc_ok_q   <= 1'b0;
      crc_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      count_q    <= count_d;
      lfsr_q     <= lfsr_d;
      rx_crc_q   <= rx_crc_d;
      crc_calc_q <= crc_calc_d;
      done_q     <= done_d;
      crc_ok_q   <= crc_ok_d;
      crc_err_q  <= crc_err_d;
    end
  end

  assign busy     = (state_q == ST_DATA) || (state_q == ST_CRC);
  assign done     = done_q;
  assign crc_ok   = crc_ok_q;
  assign crc_err  = crc_err_q;
  assign crc_calc = crc_calc_q;

endmodule

// File: tb/tb_crc_checker.sv
// Directed self-checking bench for crc_checker with hand-computed CRC-15 vectors.
module tb_crc_checker;

  logic        clk;
  logic        rst_n;
  logic        frame_start;
  logic [6:0]  data_bits;
  logic        bit_valid;
  logic        bit_in;
  logic        abort;
  logic        busy;
  logic        done;
  logic        crc_ok;
  logic        crc_err;
  logic [14:0] crc_calc;

  int n_checks;
  int n_fail;
  int done_cnt;

  crc_checker #(
    .LEN_W    (7),
    .CRC_POLY (15'h4599)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .data_bits   (data_bits),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .crc_ok      (crc_ok),
    .crc_err     (crc_err),
    .crc_calc    (crc_calc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A valid bit is offered alongside frame_start; it must not be consumed.
  task automatic start_frame(input int len);
    frame_start = 1'b1;
    data_bits   = 7'(len);
    bit_valid   = 1'b1;
    bit_in      = 1'b1;
    tick();
    frame_start = 1'b0;
    bit_valid   = 1'b0;
  endtask

  task automatic send_bits(input logic [127:0] v, input int n, input int maxgap);
    for (int i = n - 1; i >= 0; i--) begin
      int gap;
      gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      repeat (gap) tick();
      bit_valid = 1'b1;
      bit_in    = v[i];
      tick();
      bit_valid = 1'b0;
    end
  endtask

  task automatic run_frame(input string tag, input int len, input logic [127:0] data,
                           input logic [14:0] crc, input int maxgap,
                           input logic exp_ok, input logic [14:0] exp_calc);
    int d0;
    start_frame(len);
    chk({tag, ".busy_start"}, 32'(busy), 32'd1);
    send_bits(data, len, maxgap);
    send_bits(128'(crc >> 1), 14, maxgap);
    chk({tag, ".no_early_done"}, 32'(done), 32'd0);
    d0 = done_cnt;
    send_bits(128'(crc[0]), 1, maxgap);
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".ok"}, 32'(crc_ok), 32'(exp_ok));
    chk({tag, ".err"}, 32'(crc_err), 32'(!exp_ok));
    chk({tag, ".calc"}, 32'(crc_calc), 32'(exp_calc));
    tick();
    chk({tag, ".done_pulse"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, ".ok_held"}, 32'(crc_ok), 32'(exp_ok));
    chk({tag, ".busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int d0;
    n_checks    = 0;
    n_fail      = 0;
    done_cnt    = 0;
    rst_n       = 1'b0;
    frame_start = 1'b0;
    data_bits   = '0;
    bit_valid   = 1'b0;
    bit_in      = 1'b0;
    abort       = 1'b0;
    repeat (3) tick();
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.ok", 32'(crc_ok), 32'd0);
    chk("rst.err", 32'(crc_err), 32'd0);
    chk("rst.calc", 32'(crc_calc), 32'd0);
    rst_n = 1'b1;
    tick();

    run_frame("c1", 1, 128'b1, 15'h4599, 0, 1'b1, 15'h4599);
    run_frame("c2", 1, 128'b1, 15'h4598, 0, 1'b0, 15'h4599);
    run_frame("c3g", 2, 128'b10, 15'h4EAB, 5, 1'b1, 15'h4EAB);
    run_frame("c3n", 2, 128'b10, 15'h4EAB, 0, 1'b1, 15'h4EAB);
    run_frame("c4a", 8, 128'h0, 15'h0000, 2, 1'b1, 15'h0000);
    run_frame("c4b", 0, 128'h0, 15'h0000, 0, 1'b1, 15'h0000);

    // Abort after 5 CRC bits.
    d0 = done_cnt;
    start_frame(1);
    send_bits(128'b1, 1, 0);
    send_bits(128'b10001, 5, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.ok", 32'(crc_ok), 32'd0);
    chk("abort.err", 32'(crc_err), 32'd0);
    send_bits(128'h3FF, 12, 0);
    chk("abort.no_done", 32'(done_cnt - d0), 32'd0);
    run_frame("c5a", 1, 128'b1, 15'h4599, 0, 1'b1, 15'h4599);

    // Restart mid-DATA: partial frame discarded, new frame checked clean.
    d0 = done_cnt;
    start_frame(8);
    send_bits(128'b101, 3, 0);
    start_frame(1);
    chk("restart.busy", 32'(busy), 32'd1);
    send_bits(128'b1, 1, 0);
    send_bits(128'h4599, 15, 0);
    chk("restart.done", 32'(done), 32'd1);
    chk("restart.ok", 32'(crc_ok), 32'd1);
    chk("restart.calc", 32'(crc_calc), 32'h4599);
    chk("restart.one_done", 32'(done_cnt - d0), 32'd0);
    tick();
    chk("restart.done_cnt", 32'(done_cnt - d0), 32'd1);

    // frame_start in DONE: old result shown during done, then cleared, new frame runs.
    start_frame(1);
    send_bits(128'b1, 1, 0);
    send_bits(128'h4599, 15, 0);
    frame_start = 1'b1;
    data_bits   = 7'd1;
    chk("fsdone.done", 32'(done), 32'd1);
    chk("fsdone.ok_old", 32'(crc_ok), 32'd1);
    tick();
    frame_start = 1'b0;
    chk("fsdone.busy", 32'(busy), 32'd1);
    chk("fsdone.ok_clr", 32'(crc_ok), 32'd0);
    chk("fsdone.err_clr", 32'(crc_err), 32'd0);
    send_bits(128'b1, 1, 0);
    send_bits(128'h4598, 15, 0);
    chk("fsdone.err", 32'(crc_err), 32'd1);
    chk("fsdone.ok", 32'(crc_ok), 32'd0);
    tick();

    // Async reset mid-CRC.
    d0 = done_cnt;
    start_frame(1);
    send_bits(128'b1, 1, 0);
    send_bits(128'b10001, 5, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("arst.busy", 32'(busy), 32'd0);
    chk("arst.done", 32'(done), 32'd0);
    chk("arst.calc", 32'(crc_calc), 32'd0);
    chk("arst.ok", 32'(crc_ok), 32'd0);
    chk("arst.err", 32'(crc_err), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("arst.no_done", 32'(done_cnt - d0), 32'd0);
    run_frame("c6", 1, 128'b1, 15'h4599, 0, 1'b1, 15'h4599);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
